case_select_pipe: RTL and testbench
===================================

Name: case_select_pipe

Overview:
- Parametrised, pipelined successor of the combinational selector-driven offset block.
- Applies one of three case-matching semantics to a data word, chosen per transaction by a runtime mode: exact match, MSB-only wildcard add, or MSB-only wildcard subtract.
- Adds a valid/ready handshake, a 2-stage pipeline, a per-result default flag and a saturating default-hit counter.
- Sits in the SemanticFacts datapath between a stimulus source and a checker.

Parameters:
- DATA_W, 4: data and result width.
- SEL_W, 2: selector width, minimum 2.
- STEP, 1: exact-mode increment per selector value.
- LO_ADD, 10: wildcard-add offset when selector MSB is 0.
- HI_ADD, 20: wildcard-add offset when selector MSB is 1.
- CNT_W, 8: default-hit counter width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input transfer valid.
- in_ready  output  1  block can accept input.
- in_data  input  DATA_W  operand.
- in_sel  input  SEL_W  selector.
- in_mode  input  2  0 EXACT, 1 WILD_ADD, 2 WILD_SUB, 3 reserved.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  DATA_W  result.
- out_default  output  1  result came from the default branch.
- cnt_clr  input  1  synchronous clear of default_cnt.
- default_cnt  output  CNT_W  saturating count of default results delivered.

Behaviour:
- Reset (asynchronous assert, synchronous release): all stage valids, out_valid, out_data, out_default and default_cnt go to 0. in_ready is 1 immediately after reset.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Pipeline:
  - Stage 1 registers data, sel, mode and valid.
  - Stage 2 computes the result and registers out_data, out_default and out_valid.
  - Latency: 2 cycles from accept edge to out_valid.
  - Throughput: 1 per cycle.
- Stall:
  - stall = out_valid && !out_ready.
  - While stalled, both stages hold and in_ready = 0. in_ready is combinational from out_valid and out_ready.
  - Bubbles are not collapsed.
- out_data, out_default are stable while out_valid=1 and out_ready=0.
- Stage-2 function. All arithmetic is modulo 2^DATA_W; offsets are truncated to DATA_W bits.
  - EXACT: sel = k, k < 2^SEL_W-1 gives data + k*STEP, default=0. sel = all-ones gives data, default=1.
  - WILD_ADD: only sel MSB is examined. MSB 0 gives data + LO_ADD; MSB 1 gives data + HI_ADD; default=0.
  - WILD_SUB: MSB 0 gives data - 1; MSB 1 gives data - 2; default=0.
  - Mode 3: result = data, default=1.
- Counter:
  - Increments by 1 on each output transfer with out_default=1.
  - Saturates at 2^CNT_W-1.
  - cnt_clr sets it to 0; clear wins over a simultaneous increment.
- Reset mid-operation: in-flight transactions are discarded, not replayed; out_valid drops asynchronously.
- No X/Z outputs under any legal input. X/Z on in_sel in non-EXACT modes affects only the MSB decode; a non-0/1 MSB is treated as 1.

Test Plan:
1. EXACT, default params: accept data=4'h5 sel=2'b10 at edge T, out_ready=1 -> out_valid=1 at T+2, out_data=4'h7, out_default=0, default_cnt=0.
2. WILD_ADD: data=3, sel=2'b01 -> 4'hD. Next cycle data=3, sel=2'b11 -> 4'h7 (3+20 mod 16). Back-to-back results on consecutive cycles.
3. WILD_SUB wrap: data=0, sel=2'b10 -> 4'hE. data=1, sel=2'b00 -> 4'h0.
4. Defaults and counter, CNT_W=2:
   - Five transfers, EXACT sel=2'b11 data=9 -> each out_data=9, out_default=1, counter 1,2,3,3,3.
   - Mode 3 data=4 -> out_data=4, out_default=1.
   - Assert cnt_clr together with a default transfer -> default_cnt=0.
5. Backpressure: stream 4 EXACT transactions, hold out_ready=0 for 3 cycles once out_valid=1 -> in_ready=0 during the stall, out_data held, all 4 results delivered in order with none lost or duplicated.
6. Reset mid-flight: assert rst_n=0 with 2 transactions in flight -> out_valid=0 asynchronously and default_cnt=0; after release, first new result appears 2 cycles after its accept.

Source files
------------

// File: rtl/case_select_pipe.sv
// Two-stage valid/ready pipeline applying exact / MSB-wildcard add / MSB-wildcard
// subtract selection to a data word, with a default flag and saturating default-hit counter.
module case_select_pipe #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned SEL_W  = 2,
    parameter int unsigned STEP   = 1,
    parameter int unsigned LO_ADD = 10,
    parameter int unsigned HI_ADD = 20,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic [1:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_default,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  default_cnt
);

    typedef enum logic [1:0] {
        MODE_EXACT = 2'd0,
        MODE_WADD  = 2'd1,
        MODE_WSUB  = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    localparam logic [DATA_W-1:0] LO_OFF = DATA_W'(LO_ADD);
    localparam logic [DATA_W-1:0] HI_OFF = DATA_W'(HI_ADD);

    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_data;
    logic [SEL_W-1:0]  r_s1_sel;
    mode_e             r_s1_mode;

    logic              w_stall;
    logic              w_msb;
    logic [DATA_W-1:0] w_exact_off;
    logic [DATA_W-1:0] w_res;
    logic              w_def;

    assign w_stall  = out_valid && !out_ready;
    assign in_ready = !w_stall;

    // Stage 1: capture the operand, selector and mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_sel   <= '0;
            r_s1_mode  <= MODE_EXACT;
        end else if (!w_stall) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_data <= in_data;
                r_s1_sel  <= in_sel;
                r_s1_mode <= mode_e'(in_mode);
            end
        end
    end

    // Wildcard decode: any MSB value other than a clean 0 selects the high branch
    always_comb begin
        w_msb = 1'b1;
        case (r_s1_sel[SEL_W-1])
            1'b0:    w_msb = 1'b0;
            default: w_msb = 1'b1;
        endcase
    end

    assign w_exact_off = DATA_W'(32'(r_s1_sel) * STEP);

    always_comb begin
        w_res = r_s1_data;
        w_def = 1'b0;
        case (r_s1_mode)
            MODE_EXACT: begin
                if (r_s1_sel == '1) begin
                    w_def = 1'b1;
                end else begin
                    w_res = r_s1_data + w_exact_off;
                end
            end
            MODE_WADD: w_res = r_s1_data + (w_msb ? HI_OFF : LO_OFF);
            MODE_WSUB: w_res = r_s1_data - (w_msb ? DATA_W'(2) : DATA_W'(1));
            default:   w_def = 1'b1;
        endcase
    end

    // Stage 2: registered result, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_default <= 1'b0;
        end else if (!w_stall) begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_data    <= w_res;
                out_default <= w_def;
            end
        end
    end

    // Counts delivered default results; clear has priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            default_cnt <= '0;
        end else if (cnt_clr) begin
            default_cnt <= '0;
        end else if (out_valid && out_ready && out_default && (default_cnt != '1)) begin
            default_cnt <= default_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_case_select_pipe.sv
// Scoreboard bench for case_select_pipe: expected results queued on accept, compared on delivery.
module tb_case_select_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [1:0] in_sel;
    logic [1:0] in_mode;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_default;
    logic       cnt_clr;
    logic [1:0] default_cnt;

    case_select_pipe #(
        .DATA_W(4), .SEL_W(2), .STEP(1), .LO_ADD(10), .HI_ADD(20), .CNT_W(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_default(out_default), .cnt_clr(cnt_clr), .default_cnt(default_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d;
        logic       def;
        int         acc;
        bit         lat;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   model_cnt = 0;
    bit   lat_chk = 1'b1;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] d, input logic [1:0] s, input logic [1:0] m);
        exp_t e;
        int   r;
        e.def = 1'b0;
        r     = int'(d);
        case (m)
            2'd0: if (s == 2'b11) e.def = 1'b1; else r = int'(d) + int'(s);
            2'd1: r = int'(d) + (s[1] ? 20 : 10);
            2'd2: r = int'(d) + 16 - (s[1] ? 2 : 1);
            default: e.def = 1'b1;
        endcase
        e.d   = 4'(r % 16);
        e.acc = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    // Output monitor: sampled on the falling edge, transfers take effect at the next rise
    always @(negedge clk) begin
        exp_t e;
        bit   xfer_def;
        if (rst_n) begin
            xfer_def = 1'b0;
            check("default_cnt", 32'(default_cnt), 32'(model_cnt));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("out_data", 32'(out_data), 32'(e.d));
                    check("out_default", 32'(out_default), 32'(e.def));
                    if (e.lat) check("latency", 32'(cyc + 1 - e.acc), 32'd2);
                    xfer_def = e.def;
                end
            end
            if (cnt_clr) model_cnt = 0;
            else if (xfer_def && model_cnt < 3) model_cnt++;
        end
    end

    task automatic send(input logic [3:0] d, input logic [1:0] s, input logic [1:0] m);
        exp_t e;
        bit   rdy;
        int   n;
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = s;
        in_mode  = m;
        n = 0;
        forever begin
            @(negedge clk);
            rdy = in_ready;
            if (rdy) begin
                e     = model(d, s, m);
                e.acc = cyc + 1;
                e.lat = lat_chk;
                q.push_back(e);
            end
            @(posedge clk);
            #1;
            if (rdy) break;
            n++;
            if (n > 100) begin
                check("send_timeout", 32'(in_ready), 32'd1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] held;
        int         n;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; in_mode = '0;
        out_ready = 1'b1; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_cnt", 32'(default_cnt), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Exact, wildcard add back-to-back, wildcard subtract with wrap
        send(4'h5, 2'b10, 2'd0);
        drain();
        send(4'h3, 2'b01, 2'd1);
        send(4'h3, 2'b11, 2'd1);
        send(4'h0, 2'b10, 2'd2);
        send(4'h1, 2'b00, 2'd2);
        send(4'hF, 2'b01, 2'd0);
        drain();

        // Default results and saturating counter
        repeat (5) send(4'h9, 2'b11, 2'd0);
        send(4'h4, 2'b01, 2'd3);
        drain();
        check("cnt_saturated", 32'(default_cnt), 32'd3);
        cnt_clr = 1'b1;
        send(4'h9, 2'b11, 2'd0);
        drain();
        cnt_clr = 1'b0;
        check("cnt_after_clr", 32'(default_cnt), 32'd0);

        // Backpressure: stall 3 cycles once the first result is visible
        lat_chk = 1'b0;
        fork
            begin
                send(4'h1, 2'b00, 2'd0);
                send(4'h2, 2'b01, 2'd0);
                send(4'h3, 2'b10, 2'd0);
                send(4'h4, 2'b01, 2'd0);
            end
            begin
                n = 0;
                while (!out_valid && n < 20) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                check("bp_out_valid", 32'(out_valid), 32'd1);
                out_ready = 1'b0;
                held = out_data;
                repeat (3) begin
                    @(negedge clk);
                    check("bp_in_ready", 32'(in_ready), 32'd0);
                    check("bp_held", 32'(out_data), 32'(held));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        lat_chk = 1'b1;

        // Reset with two transactions in flight after a counted default
        send(4'h6, 2'b11, 2'd0);
        drain();
        send(4'h2, 2'b00, 2'd1);
        send(4'h3, 2'b00, 2'd1);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        q.delete();
        model_cnt = 0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_cnt", 32'(default_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_valid", 32'(out_valid), 32'd0);
        send(4'hA, 2'b10, 2'd2);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
